// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative read cache: controller states and
// helpers that locate the tag/index/offset fields inside a byte address.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    FILL_DONE = 2'd2
  } cache_state_e;

  localparam int unsigned BYTE_SEL_BITS = 2;

  function automatic int unsigned tag_size(input int unsigned line_size,
                                           input int unsigned index_depth,
                                           input int unsigned offset_size);
    return line_size - index_depth - offset_size - BYTE_SEL_BITS;
  endfunction

  function automatic int unsigned index_lsb(input int unsigned offset_size);
    return offset_size + BYTE_SEL_BITS;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned index_depth,
                                          input int unsigned offset_size);
    return index_depth + offset_size + BYTE_SEL_BITS;
  endfunction

endpackage

// File: rtl/way_compare.sv
// Parallel tag/valid compare across all ways of one set; reports the lowest
// matching way.
module way_compare
  import cache_pkg::*;
#(
  parameter int unsigned WAYS_LOG2 = 1,
  parameter int unsigned TAG_SIZE  = 24
) (
  input  logic [(1<<WAYS_LOG2)-1:0][TAG_SIZE-1:0] set_tags,
  input  logic [(1<<WAYS_LOG2)-1:0]               set_valid,
  input  logic [TAG_SIZE-1:0]                     req_tag,
  output logic                                    hit,
  output logic [WAYS_LOG2-1:0]                    hit_way
);

  localparam int unsigned WAYS = 1 << WAYS_LOG2;

  // Descending scan so the last assignment wins for the lowest way index.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (set_valid[w-1] && (set_tags[w-1] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAYS_LOG2'(w - 1);
      end
    end
  end

endmodule

// File: rtl/assoc_read_cache.sv
// Set-associative read-only cache: combinational hit path, word-by-word line
// refill from next-level memory, round-robin replacement and deferred flush.
module assoc_read_cache
  import cache_pkg::*;
#(
  parameter int unsigned LINE_SIZE   = 32,
  parameter int unsigned WAYS_LOG2   = 1,
  parameter int unsigned INDEX_DEPTH = 4,
  parameter int unsigned OFFSET_SIZE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [LINE_SIZE-1:0] address,
  input  logic                 flush,
  output logic [LINE_SIZE-1:0] data,
  output logic                 busywait,
  output logic                 mem_read,
  output logic [LINE_SIZE-1:0] mem_address,
  input  logic [LINE_SIZE-1:0] mem_readdata,
  input  logic                 mem_busywait
);

  localparam int unsigned TAG_SIZE = tag_size(LINE_SIZE, INDEX_DEPTH, OFFSET_SIZE);
  localparam int unsigned WAYS     = 1 << WAYS_LOG2;
  localparam int unsigned SETS     = 1 << INDEX_DEPTH;
  localparam int unsigned WORDS    = 1 << OFFSET_SIZE;
  localparam int unsigned IDX_LSB  = index_lsb(OFFSET_SIZE);
  localparam int unsigned TAG_LSB  = tag_lsb(INDEX_DEPTH, OFFSET_SIZE);

  cache_state_e             state;
  logic [OFFSET_SIZE-1:0]   word_cnt;
  logic [WAYS-1:0]          valid  [SETS];
  logic [WAYS_LOG2-1:0]     rr_ptr [SETS];
  logic                     flush_pending;
  logic [WAYS_LOG2-1:0]     victim;
  logic [WAYS_LOG2-1:0]     victim_sel;
  logic [TAG_SIZE-1:0]      miss_tag;
  logic [INDEX_DEPTH-1:0]   miss_index;

  logic [WAYS-1:0][TAG_SIZE-1:0]    tag_mem  [SETS];
  logic [WORDS-1:0][LINE_SIZE-1:0]  data_mem [SETS][WAYS];

  logic [TAG_SIZE-1:0]    req_tag;
  logic [INDEX_DEPTH-1:0] req_index;
  logic [OFFSET_SIZE-1:0] req_off;
  logic                   byte_sel_unused;
  logic                   hit;
  logic [WAYS_LOG2-1:0]   hit_way;

  assign req_tag         = address[TAG_LSB +: TAG_SIZE];
  assign req_index       = address[IDX_LSB +: INDEX_DEPTH];
  assign req_off         = address[BYTE_SEL_BITS +: OFFSET_SIZE];
  assign byte_sel_unused = ^address[BYTE_SEL_BITS-1:0];

  way_compare #(
    .WAYS_LOG2 (WAYS_LOG2),
    .TAG_SIZE  (TAG_SIZE)
  ) u_way_compare (
    .set_tags  (tag_mem[req_index]),
    .set_valid (valid[req_index]),
    .req_tag   (req_tag),
    .hit       (hit),
    .hit_way   (hit_way)
  );

  // Victim: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    victim_sel = rr_ptr[req_index];
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!valid[req_index][w-1]) victim_sel = WAYS_LOG2'(w - 1);
    end
  end

  always_comb begin
    data        = (req_valid && hit) ? data_mem[req_index][hit_way][req_off] : '0;
    busywait    = (state != IDLE) || (req_valid && !hit);
    mem_read    = (state == REFILL);
    mem_address = (state == REFILL) ?
                  {miss_tag, miss_index, word_cnt, {BYTE_SEL_BITS{1'b0}}} : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      word_cnt      <= '0;
      flush_pending <= 1'b0;
      victim        <= '0;
      miss_tag      <= '0;
      miss_index    <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        rr_ptr[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // A flush held over from a refill lands here, after the held request is served.
          if (flush || flush_pending) begin
            flush_pending <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) valid[s] <= '0;
          end
          if (req_valid && !hit) begin
            state      <= REFILL;
            victim     <= victim_sel;
            miss_tag   <= req_tag;
            miss_index <= req_index;
            word_cnt   <= '0;
          end
        end
        REFILL: begin
          if (flush) flush_pending <= 1'b1;
          if (!mem_busywait) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == '1) begin
              valid[miss_index][victim] <= 1'b1;
              rr_ptr[miss_index]        <= rr_ptr[miss_index] + 1'b1;
              state                     <= FILL_DONE;
            end
          end
        end
        FILL_DONE: begin
          if (flush) flush_pending <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == REFILL && !mem_busywait) begin
      data_mem[miss_index][victim][word_cnt] <= mem_readdata;
      if (word_cnt == '1) tag_mem[miss_index][victim] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_assoc_read_cache.sv
// Bench for assoc_read_cache: directed vector table, hand-written refill/flush/reset
// sequences and random reads checked against an abstract cache-contents model.
module tb_assoc_read_cache;

  logic        clk = 1'b0;
  logic        reset, req_valid, flush, busywait, mem_read, mem_busywait;
  logic [31:0] address, data, mem_address, mem_readdata;

  int total = 0;
  int bad   = 0;

  // Abstract model: which tags each set holds and its replacement pointer.
  bit          m_valid [16][2];
  logic [23:0] m_tag   [16][2];
  int          m_rr    [16];

  int unsigned wait_cycles = 0;
  int unsigned remaining   = 0;
  bit          active      = 1'b0;
  logic [31:0] cur_addr    = '0;

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tab [9];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign mem_readdata = mem_fn(mem_address);

  assoc_read_cache #(
    .LINE_SIZE   (32),
    .WAYS_LOG2   (1),
    .INDEX_DEPTH (4),
    .OFFSET_SIZE (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .address      (address),
    .flush        (flush),
    .data         (data),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  // Memory: each new word request is held busy for wait_cycles cycles.
  always @(negedge clk) begin
    if (mem_read) begin
      if (!active || mem_address != cur_addr) begin
        active    = 1'b1;
        cur_addr  = mem_address;
        remaining = wait_cycles;
      end
      mem_busywait = (remaining != 0);
      if (remaining != 0) remaining--;
    end else begin
      active       = 1'b0;
      mem_busywait = 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < 16; s++) begin
      m_valid[s][0] = 1'b0;
      m_valid[s][1] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    model_clear();
    for (int s = 0; s < 16; s++) m_rr[s] = 0;
  endfunction

  // Returns 1 on miss and installs the line as the cache should.
  function automatic bit model_access(input logic [31:0] a);
    int          idx;
    int          v;
    logic [23:0] tg;
    idx = int'((a >> 4) & 32'hF);
    tg  = 24'(a >> 8);
    for (int w = 0; w < 2; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tg) return 1'b0;
    if (!m_valid[idx][0])      v = 0;
    else if (!m_valid[idx][1]) v = 1;
    else                       v = m_rr[idx];
    m_valid[idx][v] = 1'b1;
    m_tag[idx][v]   = tg;
    m_rr[idx]       = (m_rr[idx] + 1) % 2;
    return 1'b1;
  endfunction

  task automatic do_read(input logic [31:0] a, input bit exp_miss, input int unsigned wcyc,
                         input int flush_at, input string nm);
    int          cyc;
    int          k;
    bit          served;
    bit          addr_ok;
    logic [31:0] line;
    wait_cycles = wcyc;
    @(negedge clk);
    req_valid = 1'b1;
    address   = a;
    #1;
    check({nm, " busy"}, 32'(busywait), 32'(exp_miss));
    if (!exp_miss) begin
      check({nm, " hitdata"}, data, mem_fn(a));
    end else if (busywait) begin
      line    = a & 32'hFFFF_FFF0;
      cyc     = 1;
      k       = 0;
      served  = 1'b0;
      addr_ok = 1'b1;
      while (!served && cyc < 200) begin
        @(negedge clk);
        #1;
        flush = (cyc == flush_at);
        if (mem_read) begin
          if (mem_address != line + 32'(4 * k)) addr_ok = 1'b0;
          if (!mem_busywait) k++;
        end
        if (!busywait) served = 1'b1;
        else cyc++;
      end
      flush = 1'b0;
      check({nm, " served"}, 32'(served), 32'd1);
      check({nm, " latency"}, 32'(cyc), 32'(4 * (wcyc + 1) + 2));
      check({nm, " memaddr"}, 32'(addr_ok), 32'd1);
      check({nm, " words"}, 32'(k), 32'd4);
      check({nm, " missdata"}, data, mem_fn(a));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bit          miss;
    bit          found;
    int          fa;

    tab[0] = '{32'h0000_0124, 1'b1, mem_fn(32'h0000_0124)};
    tab[1] = '{32'h0000_0124, 1'b0, mem_fn(32'h0000_0124)};
    tab[2] = '{32'h0000_0228, 1'b1, mem_fn(32'h0000_0228)};
    tab[3] = '{32'h0000_0120, 1'b0, mem_fn(32'h0000_0120)};
    tab[4] = '{32'h0000_032C, 1'b1, mem_fn(32'h0000_032C)};
    tab[5] = '{32'h0000_022C, 1'b0, mem_fn(32'h0000_022C)};
    tab[6] = '{32'h0000_0124, 1'b1, mem_fn(32'h0000_0124)};
    tab[7] = '{32'h0000_0324, 1'b0, mem_fn(32'h0000_0324)};
    tab[8] = '{32'h0000_0228, 1'b1, mem_fn(32'h0000_0228)};

    reset        = 1'b0;
    req_valid    = 1'b0;
    flush        = 1'b0;
    address      = '0;
    mem_busywait = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst busywait", 32'(busywait), 32'd0);
    check("rst mem_read", 32'(mem_read), 32'd0);
    check("rst mem_address", mem_address, 32'd0);
    check("rst data", data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle busywait", 32'(busywait), 32'd0);

    for (int i = 0; i < 9; i++) begin
      void'(model_access(tab[i].addr));
      do_read(tab[i].addr, tab[i].miss, 0, -1, $sformatf("tab%0d", i));
      check($sformatf("tab%0d data", i), data, tab[i].exp_data);
    end

    // Flush together with a hit: served from pre-flush contents, then gone.
    @(negedge clk);
    req_valid = 1'b1;
    address   = 32'h0000_0124;
    flush     = 1'b1;
    #1;
    check("flushhit busy", 32'(busywait), 32'd0);
    check("flushhit data", data, mem_fn(32'h0000_0124));
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    model_clear();
    void'(model_access(32'h0000_0124));
    do_read(32'h0000_0124, 1'b1, 0, -1, "afterflush");

    void'(model_access(32'h0000_1054));
    do_read(32'h0000_1054, 1'b1, 3, -1, "slowmem");

    void'(model_access(32'h0000_4460));
    do_read(32'h0000_4460, 1'b1, 1, 2, "flushmid");
    model_clear();
    void'(model_access(32'h0000_1054));
    do_read(32'h0000_1054, 1'b1, 0, -1, "postflushA");
    void'(model_access(32'h0000_4460));
    do_read(32'h0000_4460, 1'b1, 0, -1, "postflushB");

    // Reset during the third refill word.
    wait_cycles = 0;
    @(negedge clk);
    req_valid = 1'b1;
    address   = 32'h0000_0578;
    found     = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      #1;
      if (mem_read && mem_address[3:2] == 2'd2) found = 1'b1;
    end
    check("rstmid word2", 32'(found), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rstmid mem_read", 32'(mem_read), 32'd0);
    check("rstmid mem_address", mem_address, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    void'(model_access(32'h0000_0578));
    do_read(32'h0000_0578, 1'b1, 1, -1, "rstmid reread");

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
      end
      a    = (32'($urandom_range(1, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2);
      miss = model_access(a);
      fa   = (miss && $urandom_range(0, 4) == 0) ? 2 : -1;
      do_read(a, miss, $urandom_range(0, 2), fa, $sformatf("rnd%0d", i));
      if (fa > 0) model_clear();
    end

    @(negedge clk);
    req_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/assoc_read_cache.md
ASSOC_READ_CACHE -- requirements
Module: assoc_read_cache

Interface
REQ-001 Parameter LINE_SIZE, default 32, gives the address and data word width in bits.
REQ-002 Parameter WAYS_LOG2, default 1, gives log2 of the associativity (2 ways).
REQ-003 Parameter INDEX_DEPTH, default 4, gives the index width (16 sets).
REQ-004 Parameter OFFSET_SIZE, default 2, gives the word-offset width (4 words per block).
REQ-005 Derived constant TAG_SIZE SHALL equal LINE_SIZE-INDEX_DEPTH-OFFSET_SIZE-2.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port req_valid, input, 1 bit: a read request is present.
REQ-009 Port address, input, LINE_SIZE bits: byte address split as {tag, index, offset, 2'b00}.
REQ-010 Port flush, input, 1 bit: a one-cycle pulse that invalidates all lines.
REQ-011 Port data, output, LINE_SIZE bits: the read word.
REQ-012 Port busywait, output, 1 bit: the request is not yet served; the requester holds address stable.
REQ-013 Port mem_read, output, 1 bit: read request to next-level memory.
REQ-014 Port mem_address, output, LINE_SIZE bits: word address to memory, with bits [1:0]=0.
REQ-015 Port mem_readdata, input, LINE_SIZE bits: word returned by memory.
REQ-016 Port mem_busywait, input, 1 bit: memory has not yet delivered mem_readdata.

Function
REQ-017 The hit path SHALL be combinational: all 2^WAYS_LOG2 ways of the indexed set are compared; hit = valid && tag match in any way.
REQ-018 On req_valid && hit in state IDLE, data SHALL be driven the same cycle with busywait=0; if no way hits, data=0.
REQ-019 On req_valid && miss in IDLE, busywait SHALL be 1 that cycle, and the FSM SHALL enter REFILL on the next edge.
REQ-020 FSM states SHALL be IDLE, REFILL and FILL_DONE; busywait=1 in REFILL and FILL_DONE.
REQ-021 The victim way SHALL be chosen at miss entry as the first invalid way, otherwise the set's round-robin pointer, and SHALL be held for the whole refill.
REQ-022 In REFILL: mem_read=1 and mem_address={tag, index, word_cnt, 2'b00}; each cycle with mem_busywait=0, mem_readdata is written to the victim word[word_cnt] and word_cnt increments.
REQ-023 Refill SHALL fetch words 0 to 2^OFFSET_SIZE-1 in order; on the last word, the FSM writes tag and valid=1, advances the set's round-robin pointer modulo 2^WAYS_LOG2, and enters FILL_DONE.
REQ-024 FILL_DONE SHALL last exactly one cycle, with mem_read=0, and then return to IDLE, where the held request hits.
REQ-025 Miss latency SHALL be 2^OFFSET_SIZE memory handshakes plus 2 cycles.
REQ-026 word_cnt and the round-robin pointers SHALL wrap to 0 at their maximum.
REQ-027 flush in IDLE SHALL clear all valid bits at the next edge; a hit in that same cycle is still served from pre-flush state.
REQ-028 flush during REFILL or FILL_DONE SHALL be deferred and applied upon return to IDLE, after the line is installed.
REQ-029 req_valid=0 in IDLE SHALL leave all state unchanged, with busywait=0 and mem_read=0.
REQ-030 Address changes during REFILL are a protocol violation; the latched miss address SHALL govern the refill.

Reset
REQ-031 While reset=0: state=IDLE, word_cnt=0, all valid bits=0, all round-robin pointers=0, the pending-flush flag=0, busywait=0, mem_read=0, mem_address=0, data=0.
REQ-032 Tag and data arrays SHALL NOT be reset.
REQ-033 Reset asserted mid-refill SHALL abort the refill immediately; the partially filled line stays invalid.

Structure
REQ-034 The FSM state encoding and the TAG_SIZE/field-position helper constants SHALL live in the shared package cache_pkg.
REQ-035 The tag/valid compare across ways SHALL be the sub-module way_compare (inputs: set tags, set valids, request tag; outputs: hit, hit_way); data and FSM stay in assoc_read_cache.

Verification
REQ-036 Reset, then read 0x00000124 -> busywait=1, four mem reads at 0x120/0x124/0x128/0x12C, then data = the word returned for 0x124, and a second read of 0x124 hits with busywait=0 the same cycle.
REQ-037 Fill index 2 with tags 0x000001 and 0x000002, then read tag 0x000003 at index 2 -> way 0 replaced; re-reading tag 0x000001 misses and tag 0x000002 hits.
REQ-038 Set mem_busywait=1 for 3 cycles per word -> miss latency = 4 handshakes + 2 cycles, with mem_address stable while busy.
REQ-039 Pulse flush mid-refill -> the line completes and the request is served, then all reads miss.
REQ-040 Assert reset=0 during the third refill word -> mem_read=0 asynchronously, and after release a read of the same address misses.
